// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline stages: write-back control bit
// positions and the skid-buffer occupancy states.
package cpu_pipe_pkg;
  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;
endpackage

// File: rtl/wb_stage_pipe_if.sv
// MEM->WB stage bus: upstream handshake and payload, downstream handshake,
// held payload and forwarding view.
interface wb_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int WB_W   = 2
);
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [WB_W-1:0]   wb_i;
  logic [DATA_W-1:0] memdata_i;
  logic [DATA_W-1:0] aluresult_i;
  logic [ADDR_W-1:0] rd_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [WB_W-1:0]   wb_o;
  logic [DATA_W-1:0] memdata_o;
  logic [DATA_W-1:0] aluresult_o;
  logic [ADDR_W-1:0] rd_o;
  logic              regwrite_o;
  logic [DATA_W-1:0] wbdata_o;
  logic              fwd_valid_o;
  logic [ADDR_W-1:0] fwd_rd_o;
  logic [DATA_W-1:0] fwd_data_o;

  modport slave (
    input  flush_i, in_valid_i, wb_i, memdata_i, aluresult_i, rd_i, out_ready_i,
    output in_ready_o, out_valid_o, wb_o, memdata_o, aluresult_o, rd_o,
           regwrite_o, wbdata_o, fwd_valid_o, fwd_rd_o, fwd_data_o
  );

  modport master (
    output flush_i, in_valid_i, wb_i, memdata_i, aluresult_i, rd_i, out_ready_i,
    input  in_ready_o, out_valid_o, wb_o, memdata_o, aluresult_o, rd_o,
           regwrite_o, wbdata_o, fwd_valid_o, fwd_rd_o, fwd_data_o
  );
endinterface

// File: rtl/wb_stage_slot.sv
// One write-back payload entry: loads on ld_i, clears to zero on reset.
module wb_stage_slot #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int WB_W   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ld_i,
  input  logic [WB_W-1:0]   wb_i,
  input  logic [DATA_W-1:0] memdata_i,
  input  logic [DATA_W-1:0] aluresult_i,
  input  logic [ADDR_W-1:0] rd_i,
  output logic [WB_W-1:0]   wb_o,
  output logic [DATA_W-1:0] memdata_o,
  output logic [DATA_W-1:0] aluresult_o,
  output logic [ADDR_W-1:0] rd_o
);
  logic [WB_W-1:0]   wb_q;
  logic [DATA_W-1:0] mem_q;
  logic [DATA_W-1:0] alu_q;
  logic [ADDR_W-1:0] rd_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_q  <= '0;
      mem_q <= '0;
      alu_q <= '0;
      rd_q  <= '0;
    end else if (ld_i) begin
      wb_q  <= wb_i;
      mem_q <= memdata_i;
      alu_q <= aluresult_i;
      rd_q  <= rd_i;
    end
  end

  assign wb_o        = wb_q;
  assign memdata_o   = mem_q;
  assign aluresult_o = alu_q;
  assign rd_o        = rd_q;
endmodule

// File: rtl/wb_stage_pipe.sv
// MEM->WB pipeline register with valid/ready handshake, optional 2-entry
// skid buffer, flush, write-back data select and forwarding view.
module wb_stage_pipe
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int WB_W   = 2,
  parameter int SKID   = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  wb_stage_pipe_if.slave  bus
);
  logic              push, pop, flush, in_rdy, out_vld, main_ld;
  logic [WB_W-1:0]   main_wb_d;
  logic [DATA_W-1:0] main_mem_d, main_alu_d;
  logic [ADDR_W-1:0] main_rd_d;

  assign flush = bus.flush_i;
  assign push  = bus.in_valid_i & in_rdy;
  assign pop   = out_vld & bus.out_ready_i;

  generate
    if (SKID != 0) begin : g_skid
      state_e            state_q;
      logic              rdy_q, skid_ld;
      logic [WB_W-1:0]   skid_wb;
      logic [DATA_W-1:0] skid_mem, skid_alu;
      logic [ADDR_W-1:0] skid_rd;

      // in_ready is registered alongside the state so out_ready never reaches it
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          state_q <= ST_EMPTY;
          rdy_q   <= 1'b1;
        end else if (flush) begin
          state_q <= ST_EMPTY;
          rdy_q   <= 1'b1;
        end else begin
          case (state_q)
            ST_EMPTY: if (push) state_q <= ST_ONE;
            ST_ONE: begin
              if (push && !pop) begin
                state_q <= ST_TWO;
                rdy_q   <= 1'b0;
              end else if (pop && !push) begin
                state_q <= ST_EMPTY;
              end
            end
            ST_TWO: begin
              if (pop) begin
                state_q <= ST_ONE;
                rdy_q   <= 1'b1;
              end
            end
            default: begin
              state_q <= ST_EMPTY;
              rdy_q   <= 1'b1;
            end
          endcase
        end
      end

      assign skid_ld = !flush && push && !pop && (state_q == ST_ONE);
      assign main_ld = !flush && ((push && (state_q == ST_EMPTY)) ||
                                  (push && pop && (state_q == ST_ONE)) ||
                                  (pop && (state_q == ST_TWO)));
      assign main_wb_d  = (state_q == ST_TWO) ? skid_wb  : bus.wb_i;
      assign main_mem_d = (state_q == ST_TWO) ? skid_mem : bus.memdata_i;
      assign main_alu_d = (state_q == ST_TWO) ? skid_alu : bus.aluresult_i;
      assign main_rd_d  = (state_q == ST_TWO) ? skid_rd  : bus.rd_i;
      assign in_rdy  = rdy_q;
      assign out_vld = (state_q != ST_EMPTY);

      wb_stage_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WB_W(WB_W)) u_skid (
        .clk_i(clk_i), .rst_i(rst_i), .ld_i(skid_ld),
        .wb_i(bus.wb_i), .memdata_i(bus.memdata_i),
        .aluresult_i(bus.aluresult_i), .rd_i(bus.rd_i),
        .wb_o(skid_wb), .memdata_o(skid_mem),
        .aluresult_o(skid_alu), .rd_o(skid_rd)
      );
    end else begin : g_single
      logic vld_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      vld_q <= 1'b0;
        else if (flush) vld_q <= 1'b0;
        else if (push)  vld_q <= 1'b1;
        else if (pop)   vld_q <= 1'b0;
      end

      assign main_ld    = push && !flush;
      assign main_wb_d  = bus.wb_i;
      assign main_mem_d = bus.memdata_i;
      assign main_alu_d = bus.aluresult_i;
      assign main_rd_d  = bus.rd_i;
      assign in_rdy  = !vld_q || bus.out_ready_i;
      assign out_vld = vld_q;
    end
  endgenerate

  wb_stage_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WB_W(WB_W)) u_main (
    .clk_i(clk_i), .rst_i(rst_i), .ld_i(main_ld),
    .wb_i(main_wb_d), .memdata_i(main_mem_d),
    .aluresult_i(main_alu_d), .rd_i(main_rd_d),
    .wb_o(bus.wb_o), .memdata_o(bus.memdata_o),
    .aluresult_o(bus.aluresult_o), .rd_o(bus.rd_o)
  );

  assign bus.in_ready_o  = in_rdy;
  assign bus.out_valid_o = out_vld;
  // r0 is hardwired zero, so it is never reported as a write target
  assign bus.regwrite_o  = out_vld & bus.wb_o[WB_REGWRITE] & (bus.rd_o != '0);
  assign bus.wbdata_o    = bus.wb_o[WB_MEMTOREG] ? bus.memdata_o : bus.aluresult_o;
  assign bus.fwd_valid_o = bus.regwrite_o;
  assign bus.fwd_rd_o    = bus.rd_o;
  assign bus.fwd_data_o  = bus.wbdata_o;
endmodule
